// File: rtl/moldudp64_pkg.sv
// Shared types and constants for the MoldUDP64 receive path.
// Holds session FSM states, request bundle and count limits.
package moldudp64_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_END  = 2'd2
    } state_e;

    localparam logic [15:0] REQ_CNT_MAX = 16'hFFFE;
    localparam logic [15:0] END_CNT     = 16'hFFFF;

    typedef struct packed {
        logic [63:0] seq;
        logic [15:0] cnt;
    } req_t;

    // 0xFFFF is reserved for end-of-session, so gaps saturate below it
    function automatic logic [15:0] clamp_gap(input logic [63:0] d);
        if (d > {48'd0, REQ_CNT_MAX})
            return REQ_CNT_MAX;
        return d[15:0];
    endfunction

endpackage

// File: rtl/countdown.sv
// Reloadable down-counter that stops and flags at zero.
// Ports: clk, nreset (sync, low), start_v_i reload, zero_o flag.
module countdown #(
    parameter int CNT = 10,
    parameter int W   = 4
) (
    input  logic clk,
    input  logic nreset,
    input  logic start_v_i,
    output logic zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!nreset)
            cnt_q <= W'(CNT);
        else if (start_v_i)
            cnt_q <= W'(CNT);
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/session_tracker.sv
// MoldUDP64 session tracker: follows sequence numbers, raises
// one-entry gap retransmit requests, timeout and end-of-session.
// Ports: clk, nreset (sync, low); pkt_v_i/pkt_seq_i/pkt_cnt_i in;
// req_v_o/req_ready_i/req_seq_o/req_cnt_o request handshake;
// expect_seq_o, timeout_o, req_drop_o, end_o status.
module session_tracker
    import moldudp64_pkg::*;
#(
    parameter int TO_CNT   = 10000,
    parameter int TO_CNT_W = 14
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        pkt_v_i,
    input  logic [63:0] pkt_seq_i,
    input  logic [15:0] pkt_cnt_i,
    output logic        req_v_o,
    input  logic        req_ready_i,
    output logic [63:0] req_seq_o,
    output logic [15:0] req_cnt_o,
    output logic [63:0] expect_seq_o,
    output logic        timeout_o,
    output logic        req_drop_o,
    output logic        end_o
);

    state_e      state_q, state_d;
    logic [63:0] expect_q, expect_d;
    req_t        req_q, gap_req;
    logic        req_v_q, drop_q, end_q;

    logic        is_end, pkt_acc, gap_v, accept, to_zero;
    logic [15:0] eff_cnt;
    logic [63:0] sum;

    always_comb begin
        is_end  = (pkt_cnt_i == END_CNT);
        eff_cnt = is_end ? 16'd0 : pkt_cnt_i;
        sum     = pkt_seq_i + {48'd0, eff_cnt};
        pkt_acc = pkt_v_i && (state_q != ST_END);
        gap_v   = pkt_v_i && (state_q == ST_SYNC)
                  && (pkt_seq_i > expect_q);
        gap_req.seq = expect_q;
        gap_req.cnt = clamp_gap(pkt_seq_i - expect_q);
        accept  = req_v_q && req_ready_i;
    end

    // In SYNC, taking the larger of sum and expect covers in-order,
    // gap and stale-overlap packets with one comparison.
    always_comb begin
        state_d  = state_q;
        expect_d = expect_q;
        if (pkt_v_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (is_end) begin
                        state_d = ST_END;
                    end else begin
                        expect_d = sum;
                        state_d  = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (sum > expect_q)
                        expect_d = sum;
                    if (is_end)
                        state_d = ST_END;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q  <= ST_IDLE;
            expect_q <= '0;
            end_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            expect_q <= expect_d;
            if (pkt_acc && is_end)
                end_q <= 1'b1;
        end
    end

    // Held entry may be replaced only in the cycle it is accepted.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            req_v_q <= 1'b0;
            req_q   <= '0;
            drop_q  <= 1'b0;
        end else if (gap_v) begin
            if (!req_v_q || accept) begin
                req_v_q <= 1'b1;
                req_q   <= gap_req;
            end else begin
                drop_q <= 1'b1;
            end
        end else if (accept) begin
            req_v_q <= 1'b0;
        end
    end

    countdown #(
        .CNT (TO_CNT),
        .W   (TO_CNT_W)
    ) u_to (
        .clk       (clk),
        .nreset    (nreset),
        .start_v_i (pkt_acc),
        .zero_o    (to_zero)
    );

    assign req_v_o      = req_v_q;
    assign req_seq_o    = req_q.seq;
    assign req_cnt_o    = req_q.cnt;
    assign expect_seq_o = expect_q;
    assign timeout_o    = to_zero && (state_q == ST_SYNC);
    assign req_drop_o   = drop_q;
    assign end_o        = end_q;

endmodule
